s_reader: RTL and testbench
===========================

// Module: s_reader
// PURPOSE
//  Sweeps a region of the 256-byte S memory through its read port and streams the bytes out on a valid/ready interface.
//  Counterpart of the S-memory initializer: that block writes, this one reads back (dump, debug, KSA/PRGA feed).
//  Uses the same en/rdy start protocol as the other ARC4 task blocks; sits between the S RAM read port and a consumer.
// PARAMETERS
//  ADDR_W  8   S memory address width; depth = 2**ADDR_W
//  DATA_W  8   S memory / stream data width
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         synchronous reset, active-high
//  en         in   1         start request; honoured only while rdy=1
//  rdy        out  1         idle / accepting a new request
//  base       in   ADDR_W    first address, sampled with en
//  len        in   ADDR_W+1  bytes to read, 0..256, sampled with en
//  addr       out  ADDR_W    S RAM read address
//  rddata     in   DATA_W    S RAM read data, valid 1 cycle after addr issued
//  out_data   out  DATA_W    stream byte
//  out_valid  out  1         out_data valid
//  out_ready  in   1         consumer accepts when out_valid & out_ready
//  mismatch   out  1         identity-check failure (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge): rdy=1, out_valid=0, addr=0, mismatch=0; counters and FIFO cleared. Reset mid-run aborts the run; in-flight read data is dropped.
//  FSM: IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE: rdy=1. en=1 latches base and len; next cycle rdy=0, state RUN. en=0: stay.
//   len=0: go to DRAIN with nothing issued; rdy=1 two cycles after en, no stream output.
//   RUN: issue one read per cycle when issue_ok; addr = base+k mod 2**ADDR_W (wraps 255->0).
//        After len reads issued -> DRAIN.
//   DRAIN: wait until the last byte has been accepted, then IDLE; rdy rises on the cycle after that acceptance.
//  en while rdy=0 is ignored; base/len are not re-sampled.
//  Read pipeline: a read issued in cycle t returns rddata in t+1 and is written into the 2-entry FIFO at the end of t+1.
//  Flow control: issue_ok = (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready this cycle. The FIFO never overflows; no read is ever lost.
//  Throughput with out_ready held at 1: 1 byte/cycle. First out_valid 2 cycles after the first read is issued.
//  out_valid = FIFO not empty. out_data holds stable while out_valid & !out_ready.
//  Ordering: bytes leave in address order, base first.
//  Counters: issue counter and accept counter are ADDR_W+1 bits wide, so len=256 is exact.
//  addr holds its last value while idle or stalled.
// CONFIGURATION
//  S_READER_IDCHECK_EN defined: each accepted byte is compared with its own address (low DATA_W bits).
//   mismatch is sticky per run: cleared on an accepted en, set on the cycle after the first failing accept.
//  Not defined: mismatch tied to 0; no comparator logic.
// STRUCTURE
//  Package arc4_pkg:
//   - SBOX_SIZE = 256
//   - typedef byte_t (logic [7:0])
//   - typedef s_reader_state_t enum {IDLE, RUN, DRAIN}
//  Sub-module s_reader_fifo: 2-entry synchronous FIFO with push/pop/count; same-cycle push+pop allowed when full.
// TESTING
//  1. rst 2 cycles -> rdy=1, out_valid=0, mismatch=0.
//  2. RAM S[i]=i, base=0, len=256, out_ready=1 -> 256 bytes 0..255 back-to-back, mismatch=0; rdy rises 1 cycle after the last accept.
//  3. base=250, len=10 -> addr sequence 250..255,0..3; out_data matches RAM at those addresses.
//  4. len=4, out_ready toggled 1010... plus a 5-cycle hold at 0 -> no byte dropped or duplicated; out_data stable while stalled.
//  5. len=0 -> no out_valid; rdy back to 1 two cycles after en. en pulsed mid-run -> ignored.
//  6. S[7]=0xAA with S_READER_IDCHECK_EN -> mismatch=1 after the byte at address 7 is accepted, held to end of run; rst mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 types and constants for the S-memory blocks
package arc4_pkg;

  localparam int SBOX_SIZE = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } s_reader_state_t;

endpackage

// File: rtl/s_reader_if.sv
// rtl/s_reader_if.sv - valid/ready byte stream leaving the S-memory reader
interface s_reader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/s_reader_fifo.sv
// rtl/s_reader_fifo.sv - 2-entry synchronous FIFO absorbing the one-cycle RAM read latency
module s_reader_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // When full, push+pop targets the slot being read; pop sees the old value.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/s_reader.sv
// rtl/s_reader.sv - sweeps an S-memory region and streams it out; S_READER_IDCHECK_EN adds the identity check
module s_reader
  import arc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  s_reader_if.master        out_s,
  output logic              mismatch
);

  localparam int CNT_W = ADDR_W + 1;

  s_reader_state_t   state, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  accept_cnt;
  logic [ADDR_W-1:0] addr_last;
  logic [ADDR_W-1:0] addr_issue;
  logic              inflight;
  logic              issue;
  logic              issue_ok;
  logic              pop;
  logic              start;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;

  assign start     = (state == IDLE) && en;
  assign pop       = out_s.out_valid && out_s.out_ready;
  // Counts the slot a pop frees this cycle so steady streaming runs at 1 byte/cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok  = occupancy < 3'd2;

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_d = (len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (issue_cnt + CNT_W'(1) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept_cnt + CNT_W'(pop) == len_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      addr_last  <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_d;
      inflight <= issue;
      if (start) begin
        base_q     <= base;
        len_q      <= len;
        issue_cnt  <= '0;
        accept_cnt <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          addr_last <= addr_issue;
        end
        if (pop) begin
          accept_cnt <= accept_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign addr_issue = base_q + issue_cnt[ADDR_W-1:0];
  assign addr       = issue ? addr_issue : addr_last;
  assign rdy        = (state == IDLE);

  s_reader_fifo #(
    .W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (rddata),
    .pop  (pop),
    .dout (out_s.out_data),
    .count(fifo_count)
  );

  assign out_s.out_valid = (fifo_count != 2'd0);

`ifdef S_READER_IDCHECK_EN
  logic [ADDR_W-1:0] accept_addr;
  logic              mismatch_q;

  assign accept_addr = base_q + accept_cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (start) begin
      mismatch_q <= 1'b0;
    end else if (pop && (out_s.out_data != DATA_W'(accept_addr))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_s_reader.sv
// tb/tb_s_reader.sv - randomized bench for s_reader against a queue model; honours S_READER_IDCHECK_EN
module tb_s_reader;
  import arc4_pkg::*;

`ifdef S_READER_IDCHECK_EN
  localparam bit IDCHECK = 1'b1;
`else
  localparam bit IDCHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] base;
  logic [8:0] len;
  logic [7:0] addr;
  logic [7:0] rddata;
  logic       mismatch;
  byte_t      mem [SBOX_SIZE];
  int         checks = 0;
  int         failures = 0;

  s_reader_if #(.DATA_W(8)) s_if ();

  s_reader #(
    .ADDR_W(8),
    .DATA_W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rdy     (rdy),
    .base    (base),
    .len     (len),
    .addr    (addr),
    .rddata  (rddata),
    .out_s   (s_if.master),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rddata <= mem[addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always, 1: random ready, 2: 1010 toggle with a 5-cycle hold low
  task automatic run(input logic [7:0] b, input logic [8:0] l, input int mode, input bit poke_en);
    byte_t q[$];
    byte_t prev_data = 0;
    byte_t exp_b;
    int    cyc = 0;
    int    n_acc = 0;
    int    acc_cyc = -1;
    bit    prev_stall = 0;
    bit    exp_mm = 0;
    bit    done = 0;
    for (int k = 0; k < int'(l); k++) q.push_back(mem[(int'(b) + k) % SBOX_SIZE]);
    @(negedge clk);
    base = b;
    len  = l;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (!done && cyc < 3000) begin
      case (mode)
        0:       s_if.out_ready = 1'b1;
        1:       s_if.out_ready = 1'($urandom_range(0, 1));
        default: s_if.out_ready = (cyc >= 4 && cyc <= 8) ? 1'b0 : (cyc % 2 == 0);
      endcase
      en = poke_en && (cyc == 2);
      if (en) begin
        base = 8'($urandom);
        len  = 9'($urandom_range(1, 256));
      end
      #1;
      if (rdy) begin
        check("rdy_rise", cyc, (l == 0) ? 1 : acc_cyc + 1);
        done = 1;
      end else begin
        check("mismatch_run", mismatch, exp_mm);
        if (prev_stall) check("stall_hold", s_if.out_data, prev_data);
        if (s_if.out_valid && s_if.out_ready) begin
          if (q.size() == 0) begin
            check("extra_byte", 1, 0);
          end else begin
            exp_b = q.pop_front();
            check("data", s_if.out_data, exp_b);
            if (mode == 0) check("b2b_timing", cyc, n_acc + 2);
            if (exp_b != 8'(int'(b) + n_acc)) exp_mm = exp_mm | IDCHECK;
          end
          n_acc++;
          acc_cyc = cyc;
        end
        prev_stall = s_if.out_valid && !s_if.out_ready;
        prev_data  = s_if.out_data;
        @(negedge clk);
        cyc++;
      end
    end
    en = 1'b0;
    if (!done) check("rdy_timeout", 0, 1);
    check("bytes_left", q.size(), 0);
    check("mismatch_end", mismatch, exp_mm);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    base = '0;
    len  = '0;
    s_if.out_ready = 1'b0;
    for (int i = 0; i < SBOX_SIZE; i++) mem[i] = 8'(i);
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_valid", s_if.out_valid, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_addr", addr, 0);
    rst = 1'b0;

    run(8'd0, 9'd256, 0, 0);
    for (int i = 0; i < SBOX_SIZE; i++) mem[i] = 8'($urandom);
    run(8'd250, 9'd10, 0, 0);
    run(8'd5, 9'd4, 2, 0);
    run(8'd0, 9'd0, 0, 0);
    run(8'd30, 9'd20, 1, 1);
    for (int r = 0; r < 6; r++) run(8'($urandom), 9'($urandom_range(1, 40)), 1, 0);

    for (int i = 0; i < SBOX_SIZE; i++) mem[i] = 8'(i);
    mem[7] = 8'hAA;
    run(8'd0, 9'd20, 1, 0);

    @(negedge clk);
    base = 8'd0;
    len  = 9'd50;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    s_if.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_valid", s_if.out_valid, 1);
    check("mid_mismatch", mismatch, IDCHECK);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_rdy", rdy, 1);
    check("rst2_valid", s_if.out_valid, 0);
    check("rst2_mismatch", mismatch, 0);
    check("rst2_addr", addr, 0);
    rst = 1'b0;
    s_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_drop", s_if.out_valid, 0);
    run(8'd100, 9'd8, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
